prg_monitor: RTL and testbench
==============================

# prg_monitor

Byte-stream command interpreter that owns the CPU's programmer (monitor) memory port. It takes received bytes from an external UART receiver and executes load, write, read and dump commands against memory through prg_we/prg_MA/prg_WD/prg_RD. Reply bytes go to an external UART transmitter. It also holds the CPU in reset until released.

## Interface
- READ_LAT, default 1: cycles from a prg_MA change until prg_RD is valid.
- TIMEOUT_CYC, default 24'd5_000_000: idle cycles allowed between bytes inside a command. 0 disables the timeout.
- clock  in  1  single system clock. The top ties the memory prg_clock to this same clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe per received byte. There is no backpressure.
- tx_data  out  8  reply byte.
- tx_valid  out  1  reply byte available.
- tx_ready  in  1  transmitter accepts. A transfer occurs on any cycle where tx_valid and tx_ready are both high.
- prg_we  out  1  memory write enable, one cycle per byte written.
- prg_MA  out  8  memory address, registered.
- prg_WD  out  8  memory write data, registered.
- prg_RD  in  8  memory read data.
- cpu_hold  out  1  CPU held in reset while high.
- busy  out  1  high whenever state is not S_IDLE.
- err_overrun  out  1  sticky flag, set when an rx byte is dropped. Cleared only by reset.

## Operation
- Commands are uppercase ASCII; operands are raw bytes.
  - 'W'(0x57) addr data: write one byte, reply 'K'(0x4B).
  - 'R'(0x52) addr: reply with one memory byte.
  - 'D'(0x44) addr len: reply with len consecutive bytes.
  - 'L'(0x4C) addr len d0..d(len-1): write len bytes, reply 'K' after the last byte.
  - 'G'(0x47): cpu_hold<=0, reply 'K'.
  - 'H'(0x48): cpu_hold<=1, reply 'K'.
  - Any other byte received in S_IDLE: reply '?'(0x3F).
- len is 8 bits; len=0 means 256. Use a 9-bit remaining counter. 'W' is handled as len=1 load; 'R' as len=1 dump.
- States:
  - S_IDLE: waits for a command byte.
  - S_ADDR, S_LEN, S_DATA: collect operand bytes.
  - S_WR: lasts exactly one cycle with prg_we=1. Then addr+1; remaining-1; go to S_DATA, or to S_TX with 'K' if remaining reaches 0.
  - S_RD: lasts READ_LAT+1 cycles, then captures prg_RD into tx_data.
  - S_TX: holds tx_valid and tx_data stable until the handshake. Then returns to S_IDLE, or for a dump with bytes remaining does addr+1, remaining-1 and goes to S_RD.
- Address increments wrap mod 256 (0xFF -> 0x00). A dump or load may cross the wrap.
- rx_valid during S_WR, S_RD or S_TX: the byte is dropped, err_overrun<=1, and the current command continues unaffected.
- Timeout: in S_ADDR, S_LEN or S_DATA, count cycles without rx_valid. When the count reaches TIMEOUT_CYC, return to S_IDLE silently. Writes already committed stay committed.
- Memory commands are legal regardless of cpu_hold.
- Asynchronous reset mid-command: return immediately to S_IDLE and abort any in-progress prg_we or tx_valid.

## Timing
- Reset values:
  - tx_valid=0, tx_data=0x00.
  - prg_we=0, prg_MA=0x00, prg_WD=0x00.
  - cpu_hold=1.
  - busy=0, err_overrun=0.
- Write: if the data byte is strobed in cycle n, then in cycle n+1 prg_we=1 with prg_MA and prg_WD already valid.
- Read/dump: if the last operand byte is strobed in cycle n, then:
  - prg_MA=addr from cycle n+1;
  - prg_RD is captured at the end of cycle n+1+READ_LAT;
  - tx_valid rises in cycle n+2+READ_LAT.
- Following dump bytes: after a handshake in cycle m, prg_MA increments in m+1 and the next tx_valid rises in m+2+READ_LAT.
- Replies 'K' and '?' raise tx_valid the cycle after the triggering byte or write.
- tx_valid never drops without a handshake, except on reset.
- Timeout counter is 24 bits and is reset on every accepted rx_valid.

## Structure
- Package prg_monitor_pkg holds:
  - state enum typedef (S_IDLE, S_ADDR, S_LEN, S_DATA, S_WR, S_RD, S_TX);
  - command localparams CMD_W, CMD_R, CMD_D, CMD_L, CMD_G, CMD_H;
  - reply localparams RSP_OK=0x4B and RSP_ERR=0x3F.
- Single module; no sub-module. UART rx/tx stay outside this block.

## Test plan
- Reset release: all outputs at reset values, cpu_hold=1. Then 'W',0x10,0xA5 -> one prg_we pulse with MA=0x10, WD=0xA5, then tx 'K'.
- 'L',0xFE,0x03,0x11,0x22,0x33 -> writes at 0xFE, 0xFF, 0x00 (address wrap), then one 'K'. Follow with 'D',0xFE,0x03 -> tx 0x11, 0x22, 0x33.
- 'D',0x00,0x00 with tx_ready toggling randomly -> exactly 256 bytes, tx_data stable while stalled, tx_valid never drops early.
- Unknown byte 0x41 in S_IDLE -> tx '?'. Then 'G' -> cpu_hold=0 and 'K'; 'H' -> cpu_hold=1 and 'K'.
- Extra rx_valid during a dump -> err_overrun=1, dump output unchanged.
- With TIMEOUT_CYC=100: 'L',0x20,0x02,0x55 then silence -> one write at 0x20, return to S_IDLE after 100 cycles, no reply.
- Reset asserted mid-'L': immediate return to S_IDLE with prg_we=0.

Source files
------------

// File: rtl/prg_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prg_monitor_pkg
// Purpose  : Shared types and constants for the programmer monitor: the
//            command-interpreter state encoding, the ASCII command bytes it
//            recognises and the reply bytes it sends back.
// Revision : 1.0  initial release
// ============================================================================
package prg_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_WR   = 3'd4,
    S_RD   = 3'd5,
    S_TX   = 3'd6
  } state_t;

  localparam logic [7:0] CMD_W = 8'h57;  // 'W' write one byte
  localparam logic [7:0] CMD_R = 8'h52;  // 'R' read one byte
  localparam logic [7:0] CMD_D = 8'h44;  // 'D' dump len bytes
  localparam logic [7:0] CMD_L = 8'h4C;  // 'L' load len bytes
  localparam logic [7:0] CMD_G = 8'h47;  // 'G' release CPU
  localparam logic [7:0] CMD_H = 8'h48;  // 'H' hold CPU

  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

endpackage
`default_nettype wire

// File: rtl/prg_monitor.sv
`default_nettype none
// ============================================================================
// Module   : prg_monitor
// Purpose  : Byte-stream command interpreter owning the CPU's programmer
//            memory port. Executes W/R/D/L/G/H commands received from a UART
//            receiver and returns reply bytes to a UART transmitter. Holds the
//            CPU in reset (cpu_hold) until released with 'G'.
// Ports    : clock        system clock (memory port runs on the same clock)
//            reset        asynchronous, active-low reset
//            rx_data/rx_valid   received byte + one-cycle strobe
//            tx_data/tx_valid/tx_ready   reply byte, valid/ready handshake
//            prg_we/prg_MA/prg_WD/prg_RD programmer memory port
//            cpu_hold     CPU held in reset while high
//            busy         interpreter is not idle
//            err_overrun  sticky: a received byte was dropped
// Revision : 1.0  initial release
// ============================================================================
module prg_monitor
  import prg_monitor_pkg::*;
#(
  parameter int          READ_LAT    = 1,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       prg_we,
  output logic [7:0] prg_MA,
  output logic [7:0] prg_WD,
  input  logic [7:0] prg_RD,
  output logic       cpu_hold,
  output logic       busy,
  output logic       err_overrun
);

  localparam logic [7:0] c_read_lat = 8'(READ_LAT);

  state_t      r_state;
  logic        r_is_dump;   // current memory command reads (R/D) vs writes (W/L)
  logic        r_single;    // W/R: length is implicitly 1, no length byte
  logic [8:0]  r_rem;       // bytes remaining including the current one; 256 fits
  logic [7:0]  r_lat_cnt;   // cycles spent in S_RD waiting for prg_RD
  logic [23:0] r_tmo;       // idle cycles since last byte while collecting operands

  logic w_collect;
  logic w_tmo_hit;

  assign w_collect = (r_state == S_ADDR) || (r_state == S_LEN) || (r_state == S_DATA);
  assign w_tmo_hit = (TIMEOUT_CYC != 24'd0) && (r_tmo == TIMEOUT_CYC - 24'd1);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_is_dump   <= 1'b0;
      r_single    <= 1'b0;
      r_rem       <= 9'd0;
      r_lat_cnt   <= 8'd0;
      r_tmo       <= 24'd0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      prg_we      <= 1'b0;
      prg_MA      <= 8'h00;
      prg_WD      <= 8'h00;
      cpu_hold    <= 1'b1;
      err_overrun <= 1'b0;
    end else begin
      // Operand inactivity timer; any accepted byte or leaving the operand
      // states restarts it.
      if (w_collect && !rx_valid) r_tmo <= r_tmo + 24'd1;
      else                        r_tmo <= 24'd0;

      // The interpreter has no input buffer: bytes arriving while it is busy
      // with memory or the transmitter are lost and flagged.
      if (rx_valid && ((r_state == S_WR) || (r_state == S_RD) || (r_state == S_TX)))
        err_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_W: begin r_is_dump <= 1'b0; r_single <= 1'b1; r_state <= S_ADDR; end
              CMD_L: begin r_is_dump <= 1'b0; r_single <= 1'b0; r_state <= S_ADDR; end
              CMD_R: begin r_is_dump <= 1'b1; r_single <= 1'b1; r_state <= S_ADDR; end
              CMD_D: begin r_is_dump <= 1'b1; r_single <= 1'b0; r_state <= S_ADDR; end
              CMD_G: begin
                cpu_hold  <= 1'b0;
                r_is_dump <= 1'b0;
                tx_data   <= RSP_OK;
                tx_valid  <= 1'b1;
                r_state   <= S_TX;
              end
              CMD_H: begin
                cpu_hold  <= 1'b1;
                r_is_dump <= 1'b0;
                tx_data   <= RSP_OK;
                tx_valid  <= 1'b1;
                r_state   <= S_TX;
              end
              default: begin
                r_is_dump <= 1'b0;
                tx_data   <= RSP_ERR;
                tx_valid  <= 1'b1;
                r_state   <= S_TX;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            prg_MA <= rx_data;
            if (r_single) begin
              r_rem     <= 9'd1;
              r_lat_cnt <= 8'd0;
              r_state   <= r_is_dump ? S_RD : S_DATA;
            end else begin
              r_state <= S_LEN;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end
        end

        S_LEN: begin
          if (rx_valid) begin
            r_rem     <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            r_lat_cnt <= 8'd0;
            r_state   <= r_is_dump ? S_RD : S_DATA;
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            prg_WD  <= rx_data;
            prg_we  <= 1'b1;
            r_state <= S_WR;
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end
        end

        S_WR: begin
          prg_we <= 1'b0;
          prg_MA <= prg_MA + 8'd1;
          r_rem  <= r_rem - 9'd1;
          if (r_rem == 9'd1) begin
            tx_data  <= RSP_OK;
            tx_valid <= 1'b1;
            r_state  <= S_TX;
          end else begin
            r_state <= S_DATA;
          end
        end

        S_RD: begin
          // prg_MA has been stable since entry; prg_RD is valid READ_LAT
          // cycles later, so capture on the (READ_LAT+1)-th cycle.
          if (r_lat_cnt == c_read_lat) begin
            tx_data  <= prg_RD;
            tx_valid <= 1'b1;
            r_state  <= S_TX;
          end else begin
            r_lat_cnt <= r_lat_cnt + 8'd1;
          end
        end

        S_TX: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (r_is_dump && (r_rem != 9'd1)) begin
              prg_MA    <= prg_MA + 8'd1;
              r_rem     <= r_rem - 9'd1;
              r_lat_cnt <= 8'd0;
              r_state   <= S_RD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prg_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_prg_monitor
// Purpose  : Directed self-checking bench for prg_monitor with a behavioural
//            one-cycle-latency memory on the programmer port.
// Revision : 1.0  initial release
// ============================================================================
module tb_prg_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       prg_we;
  logic [7:0] prg_MA;
  logic [7:0] prg_WD;
  logic [7:0] prg_RD = 8'h00;
  logic       cpu_hold;
  logic       busy;
  logic       err_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  logic [7:0] wr_a_q [$];
  logic [7:0] wr_d_q [$];
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  prg_monitor #(
    .READ_LAT    (1),
    .TIMEOUT_CYC (24'd100)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .prg_we      (prg_we),
    .prg_MA      (prg_MA),
    .prg_WD      (prg_WD),
    .prg_RD      (prg_RD),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  always #5 clock = ~clock;

  // Memory with one cycle read latency, plus a log of every write strobe.
  always @(posedge clock) begin
    if (prg_we) begin
      mem[prg_MA] <= prg_WD;
      wr_a_q.push_back(prg_MA);
      wr_d_q.push_back(prg_WD);
    end
    prg_RD <= mem[prg_MA];
  end

  // A stalled reply must stay valid with unchanged data until accepted.
  always @(posedge clock) begin
    if (!reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_viol++;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic handshake();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic wait_tx(input int max, output bit ok);
    int i;
    i = 0;
    while (!tx_valid && i < max) begin
      tick();
      i++;
    end
    ok = tx_valid;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_tests++; if ({prg_we, prg_MA, prg_WD} !== 17'h0) begin n_fail++; $display("FAIL reset_prg: got we=%b MA=%h WD=%h want 0/00/00", prg_we, prg_MA, prg_WD); end
    n_tests++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
    n_tests++; if ({busy, err_overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_ovr: got %b%b want 00", busy, err_overrun); end
    #2 reset = 1'b1;
    tick();
    n_tests++; if (busy !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL post_reset: got busy=%b hold=%b want 0/1", busy, cpu_hold); end
  endtask

  task automatic test_write();
    int base;
    base = wr_a_q.size();
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'hA5);
    n_tests++; if ({prg_we, prg_MA, prg_WD} !== {1'b1, 8'h10, 8'hA5}) begin n_fail++; $display("FAIL write_strobe: got we=%b MA=%h WD=%h want 1/10/a5", prg_we, prg_MA, prg_WD); end
    tick();
    n_tests++; if (prg_we !== 1'b0) begin n_fail++; $display("FAIL write_one_pulse: got we=%b want 0", prg_we); end
    n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin n_fail++; $display("FAIL write_reply: got v=%b d=%h want 1/4b", tx_valid, tx_data); end
    handshake();
    n_tests++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL write_done: got v=%b busy=%b want 0/0", tx_valid, busy); end
    n_tests++; if (wr_a_q.size() - base !== 1) begin n_fail++; $display("FAIL write_count: got %0d want 1", wr_a_q.size() - base); end
    exp_mem[8'h10] = 8'hA5;
  endtask

  task automatic test_load_wrap();
    int base;
    bit ok;
    logic [7:0] exp_a [3];
    logic [7:0] exp_d [3];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    base = wr_a_q.size();
    send_byte(8'h4C);
    send_byte(8'hFE);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL load_early_reply: got v=%b want 0 at byte %0d", tx_valid, i); end
      send_byte(exp_d[i]);
      tick();
    end
    n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin n_fail++; $display("FAIL load_reply: got v=%b d=%h want 1/4b", tx_valid, tx_data); end
    handshake();
    n_tests++; if (wr_a_q.size() - base !== 3) begin n_fail++; $display("FAIL load_count: got %0d want 3", wr_a_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < wr_a_q.size()) begin
        n_tests++;
        if (wr_a_q[base+i] !== exp_a[i] || wr_d_q[base+i] !== exp_d[i]) begin
          n_fail++; $display("FAIL load_wr%0d: got %h<=%h want %h<=%h", i, wr_a_q[base+i], wr_d_q[base+i], exp_a[i], exp_d[i]);
        end
      end
      exp_mem[exp_a[i]] = exp_d[i];
    end
    send_byte(8'h44);
    send_byte(8'hFE);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      wait_tx(20, ok);
      n_tests++; if (!ok || tx_data !== exp_d[i]) begin n_fail++; $display("FAIL dump3_byte%0d: got v=%b d=%h want 1/%h", i, ok, tx_data, exp_d[i]); end
      if (ok) handshake();
    end
    tick();
    n_tests++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dump3_end: got v=%b busy=%b want 0/0", tx_valid, busy); end
  endtask

  task automatic test_dump256();
    int idx, cyc, bad;
    logic [7:0] a;
    idx = 0; cyc = 0; bad = 0;
    stall_viol = 0;
    send_byte(8'h44);
    send_byte(8'h00);
    send_byte(8'h00);
    while (idx < 256 && cyc < 6000) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin
        a = idx[7:0];
        if (tx_data !== exp_mem[a]) begin
          bad++;
          if (bad < 5) $display("FAIL dump256_byte%0d: got %h want %h", idx, tx_data, exp_mem[a]);
        end
        idx++;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL dump256_data: got %0d bad bytes want 0", bad); end
    n_tests++; if (idx != 256) begin n_fail++; $display("FAIL dump256_count: got %0d want 256", idx); end
    repeat (8) tick();
    n_tests++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dump256_extra: got v=%b busy=%b want 0/0", tx_valid, busy); end
    n_tests++; if (stall_viol != 0) begin n_fail++; $display("FAIL dump256_stall: got %0d violations want 0", stall_viol); end
  endtask

  task automatic test_unknown_go_halt();
    send_byte(8'h41);
    n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin n_fail++; $display("FAIL unknown_reply: got v=%b d=%h want 1/3f", tx_valid, tx_data); end
    handshake();
    send_byte(8'h47);
    n_tests++; if (cpu_hold !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin n_fail++; $display("FAIL go: got hold=%b v=%b d=%h want 0/1/4b", cpu_hold, tx_valid, tx_data); end
    handshake();
    send_byte(8'h48);
    n_tests++; if (cpu_hold !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin n_fail++; $display("FAIL halt: got hold=%b v=%b d=%h want 1/1/4b", cpu_hold, tx_valid, tx_data); end
    handshake();
  endtask

  task automatic test_overrun();
    bit ok;
    n_tests++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: got %b want 0", err_overrun); end
    send_byte(8'h44);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'h57);  // lands in S_RD and must be dropped
    n_tests++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b want 1", err_overrun); end
    wait_tx(20, ok);
    n_tests++; if (!ok || tx_data !== exp_mem[8'h10]) begin n_fail++; $display("FAIL overrun_byte0: got v=%b d=%h want 1/%h", ok, tx_data, exp_mem[8'h10]); end
    if (ok) handshake();
    wait_tx(20, ok);
    n_tests++; if (!ok || tx_data !== exp_mem[8'h11]) begin n_fail++; $display("FAIL overrun_byte1: got v=%b d=%h want 1/%h", ok, tx_data, exp_mem[8'h11]); end
    if (ok) handshake();
    tick();
    n_tests++; if (busy !== 1'b0 || err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_end: got busy=%b ovr=%b want 0/1", busy, err_overrun); end
  endtask

  task automatic test_timeout();
    int base, c;
    base = wr_a_q.size();
    send_byte(8'h4C);
    send_byte(8'h20);
    send_byte(8'h02);
    send_byte(8'h55);
    tick();
    c = 0;
    while (busy && c < 200) begin
      tick();
      c++;
    end
    n_tests++; if (c < 98 || c > 102) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 100", c); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_reply: got v=%b want 0", tx_valid); end
    n_tests++;
    if (wr_a_q.size() - base !== 1 || wr_a_q[base] !== 8'h20 || wr_d_q[base] !== 8'h55) begin
      n_fail++; $display("FAIL timeout_write: got %0d writes want one 20<=55", wr_a_q.size() - base);
    end
    exp_mem[8'h20] = 8'h55;
  endtask

  task automatic test_reset_mid_load();
    int base;
    bit ok;
    send_byte(8'h4C);
    send_byte(8'h30);
    send_byte(8'h03);
    send_byte(8'h66);
    base = wr_a_q.size();
    #2 reset = 1'b0;
    #1;
    n_tests++; if (prg_we !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset: got we=%b busy=%b v=%b want 0/0/0", prg_we, busy, tx_valid); end
    n_tests++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_ovr: got %b want 0", err_overrun); end
    tick();
    #2 reset = 1'b1;
    repeat (3) tick();
    n_tests++; if (wr_a_q.size() !== base) begin n_fail++; $display("FAIL midreset_nowrite: got %0d writes want 0", wr_a_q.size() - base); end
    send_byte(8'h52);
    send_byte(8'h30);
    wait_tx(20, ok);
    n_tests++; if (!ok || tx_data !== exp_mem[8'h30]) begin n_fail++; $display("FAIL midreset_read: got v=%b d=%h want 1/%h", ok, tx_data, exp_mem[8'h30]); end
    if (ok) handshake();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    test_reset();
    test_write();
    test_load_wrap();
    test_dump256();
    test_unknown_go_halt();
    test_overrun();
    test_timeout();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
